// File: rtl/booth_pp_accum.sv
// booth_pp_accum
//   Iterative radix-4 Booth multiplier. It consumes the five partial-product
//   candidates from the candidate generator (+A, ~A, +2A, ~2A, zero) and an
//   unsigned multiplier B. It recodes one Booth digit per cycle and
//   accumulates the shifted partial products. It returns the unsigned
//   2*WIDTH-bit product A*B.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready.
//   A source holds valid (and its payload) until that edge. A sink may raise
//   or lower ready at any time.
//   - Input side: in_valid/in_ready. in_ready is high only while idle.
//   - Output side: out_valid/out_ready. product is stable while out_valid.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid, in_ready  operand/candidate handshake
//   mplr                unsigned multiplier B
//   pp_in, pp_in_n      +A and one's-complement -A candidates (WIDTH+1 bits)
//   pp_in_2, pp_in_2n   +2A and one's-complement -2A candidates
//   pp_zero             zero candidate
//   out_valid, out_ready product handshake
//   product             unsigned A*B (2*WIDTH bits), held until next result
//   busy                high while a job is in flight or waiting to be taken
//
// Optional feature: define BOOTH_EARLY_TERM_EN to finish as soon as all
//   remaining Booth digits are zero. The product value is unchanged.
//   Without it, every job takes NDIG cycles.

module booth_pp_accum #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     mplr,
    input  logic [WIDTH:0]       pp_in,
    input  logic [WIDTH:0]       pp_in_n,
    input  logic [WIDTH:0]       pp_in_2,
    input  logic [WIDTH:0]       pp_in_2n,
    input  logic [WIDTH:0]       pp_zero,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int NDIG = WIDTH / 2 + 1;
    localparam int ACCW = 2 * WIDTH + 4;
    localparam int CW   = $clog2(NDIG + 1);

    generate
        if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
            $error("booth_pp_accum: WIDTH must be even and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_nx;
    // Multiplier stored as {00, B, 0}. It shifts right two bits per digit,
    // so bits [2:0] are always the current recode triple {b[2i+1], b[2i], b[2i-1]}.
    logic [WIDTH+2:0]  bsh;
    logic [WIDTH:0]    c_p, c_n, c_2, c_2n, c_z;
    logic [ACCW-1:0]   acc;
    logic [CW-1:0]     dig;

    logic [WIDTH:0]    sel;
    logic              neg;
    logic [ACCW-1:0]   ext;
    logic [ACCW-1:0]   addend;
    logic [ACCW-1:0]   acc_nx;
    logic              accept;
    logic              last_digit;
    logic              done_now;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;

    // Digit recode and candidate selection
    always_comb begin
        sel = c_z;
        neg = 1'b0;
        unique case (bsh[2:0])
            3'b001, 3'b010: sel = c_p;
            3'b011:         sel = c_2;
            3'b100: begin
                sel = c_2n;
                neg = 1'b1;
            end
            3'b101, 3'b110: begin
                sel = c_n;
                neg = 1'b1;
            end
            default:        sel = c_z;
        endcase
    end

    // Negative candidates are one's complements, so they are one-extended.
    // The missing +1 is added at the same digit weight.
    always_comb begin
        ext    = neg ? {{(ACCW-WIDTH-1){1'b1}}, sel} : {{(ACCW-WIDTH-1){1'b0}}, sel};
        addend = (ext + {{(ACCW-1){1'b0}}, neg}) << {dig, 1'b0};
        acc_nx = acc + addend;
    end

    assign last_digit = (dig == CW'(NDIG - 1));

`ifdef BOOTH_EARLY_TERM_EN
    // bsh[WIDTH+2:2] holds b[..:2i+1]. If these bits are all zero, every
    // later digit recodes to zero.
    assign done_now = last_digit || (bsh[WIDTH+2:2] == '0);
`else
    assign done_now = last_digit;
`endif

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (in_valid) state_nx = RUN;
            RUN:     if (done_now) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bsh     <= '0;
            c_p     <= '0;
            c_n     <= '0;
            c_2     <= '0;
            c_2n    <= '0;
            c_z     <= '0;
            acc     <= '0;
            dig     <= '0;
            product <= '0;
        end else if (accept) begin
            bsh  <= {2'b00, mplr, 1'b0};
            c_p  <= pp_in;
            c_n  <= pp_in_n;
            c_2  <= pp_in_2;
            c_2n <= pp_in_2n;
            c_z  <= pp_zero;
            acc  <= '0;
            dig  <= '0;
        end else if (state == RUN) begin
            acc <= acc_nx;
            bsh <= bsh >> 2;
            dig <= dig + CW'(1);
            if (done_now) begin
                product <= acc_nx[2*WIDTH-1:0];
            end
        end
    end

endmodule

// File: doc/booth_pp_accum.md
Name: booth_pp_accum

Overview:
- Consumer side of the radix-4 Booth partial-product candidate generator.
- Accepts the five WIDTH+1-bit candidate buses (+A, ~A, +2A, ~2A, zero) together with an unsigned multiplier B.
- Recodes B one radix-4 digit per cycle, selects a candidate, applies the +1 two's-complement compensation for negative selections, and accumulates the shifted partial products.
- Returns the unsigned 2*WIDTH product over a valid/ready handshake; it is the iterative multiplier datapath behind the candidate generator.

Parameters:
- WIDTH, 16, operand width; must be even and >= 4 (elaboration error otherwise).
- NDIG, WIDTH/2+1, derived, number of Booth digits processed (localparam).

Ports:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand/candidate set offered.
- in_ready  output  1  block idle, can accept.
- mplr  input  WIDTH  unsigned multiplier B.
- pp_in  input  WIDTH+1  +A candidate ({0,A}).
- pp_in_n  input  WIDTH+1  -A one's complement candidate.
- pp_in_2  input  WIDTH+1  +2A candidate ({A,0}).
- pp_in_2n  input  WIDTH+1  -2A one's complement candidate.
- pp_zero  input  WIDTH+1  zero candidate.
- out_valid  output  1  product available.
- out_ready  input  1  consumer takes product.
- product  output  2*WIDTH  unsigned A*B.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, out_valid=0, product=0, busy=0, accumulator/digit counter=0. in_ready=1 whenever state==IDLE, including the first cycle after reset release.
- States: IDLE, RUN, DONE.
- IDLE: on in_valid&in_ready edge, register all five candidates and mplr, clear the accumulator, set digit i=0, go to RUN.
- Inputs are ignored outside IDLE; the source may change them freely after acceptance.
- RUN processes digit i each cycle. Recode bits {b[2i+1], b[2i], b[2i-1]}, with b[-1]=0 and b[WIDTH+1:WIDTH]=0:
  - 000/111 -> pp_zero
  - 001/010 -> pp_in
  - 011 -> pp_in_2
  - 100 -> pp_in_2n, neg=1
  - 101/110 -> pp_in_n, neg=1
- Extension rule: positive selections zero-extend to the accumulator width; negative selections one-extend; add neg as +1 at the same weight.
- Accumulator update: acc += (ext(sel) + neg) << 2i. The accumulator is at least 2*WIDTH+2 bits; the result is taken modulo 2^(2*WIDTH).
- After digit NDIG-1, load product from acc[2*WIDTH-1:0], assert out_valid, go to DONE. product must equal A*B exactly.
- Latency: the accept edge is cycle 0; out_valid rises after edge NDIG (9 cycles for WIDTH=16).
- DONE: out_valid and product are held stable until out_valid&out_ready. On that edge: out_valid=0, state=IDLE, in_ready=1 in the next cycle.
- product keeps its last value until the next completion.
- No overlap: a new operand cannot be accepted in the same cycle a product is taken, which gives one dead cycle between jobs.
- Reset asserted mid-RUN or in DONE aborts immediately to reset values; no partial product is ever presented.
- in_valid held with no acceptance (not IDLE) causes no state change.

Optional Feature:
- BOOTH_EARLY_TERM_EN defined: after processing digit i in RUN, if b[WIDTH-1:2i+1]==0 (all remaining digits zero), go to DONE immediately.
  - Latency becomes (index of last nonzero digit)+1, minimum 1 cycle.
  - The product value is unchanged.
- BOOTH_EARLY_TERM_EN undefined: fixed NDIG-cycle latency.

Test Plan:
- A=3, B=5, out_ready=1 -> product=0x0000000F; out_valid rises 9 cycles after accept (2 with BOOTH_EARLY_TERM_EN); in_ready low throughout.
- A=0xFFFF, B=0xFFFF -> product=0xFFFE0001 (exercises the -A digits and the top +1 digit).
- A=0xAAAA, B=0x5555 -> 0x38E31C72; A=0x0001, B=0x8000 -> 0x00008000 (top digit {0,0,b15}).
- B=0, A=0x1234 -> product=0; latency 9 cycles, or 1 cycle with BOOTH_EARLY_TERM_EN.
- Backpressure: out_ready=0 for 5 cycles after out_valid while in_valid=1 with new operands -> product/out_valid stable, no acceptance. Release out_ready -> handshake; next job accepted 1 cycle later.
- rst_n pulsed low at digit 4 of a job -> out_valid=0, busy=0 asynchronously. Then A=7, B=9 -> product=63 with normal latency and no stale accumulation.
